divider: RTL



---
 rtl/mdu_pkg.sv | 15 +
 rtl/div_step.sv | 26 ++
 rtl/divider.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: default width, divider FSM
// encoding and the quotient pattern returned for a zero divisor.
package mdu_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = '1;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: brings in the next dividend bit,
// trial-subtracts the divisor and keeps the difference only if it is non-negative.
module div_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  // One guard bit above the partial remainder keeps the trial sign exact.
  logic signed [WIDTH+1:0] shifted;
  logic signed [WIDTH+1:0] trial;

  always_comb begin
    shifted  = $signed({rem, dvd_bit});
    trial    = shifted - $signed({2'b00, divisor});
    q_bit    = ~trial[WIDTH+1];
    rem_next = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/divider.sv
// Iterative signed divider: restoring division on operand magnitudes, one
// quotient bit per clock, signs applied when the last bit is produced.
module divider
  import mdu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_begin,
  input  logic [WIDTH-1:0] div_op1,
  input  logic [WIDTH-1:0] div_op2,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic             busy,
  output logic             div_end
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state;
  div_state_e       state_nx;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic             q_sign;
  logic             r_sign;
  logic             ovf_pend;
  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic             last_step;
  logic             op2_zero;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    // -MIN_NEG wraps to itself, which is the correct unsigned magnitude.
    return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic neg,
                                                  input logic [WIDTH-1:0] mag);
    return neg ? -mag : mag;
  endfunction

  // The working dividend register doubles as the quotient accumulator.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd_bit  (dvd[WIDTH-1]),
    .divisor  (dvs),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  assign op2_zero  = (div_op2 == '0);
  assign last_step = (state == CALC) && (count == CW'(WIDTH-1));
  assign busy      = (state == CALC);
  assign div_end   = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (div_begin) state_nx = op2_zero ? DONE : CALC;
      CALC:    if (last_step) state_nx = DONE;
      DONE:    if (!div_begin) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control and architectural outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          count <= '0;
          if (div_begin && op2_zero) begin
            quotient    <= WIDTH'(DIV_BY_ZERO_Q);
            remainder   <= div_op1;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end
        end
        CALC: begin
          count <= count + 1'b1;
          if (last_step) begin
            quotient    <= apply_sign(q_sign, {dvd[WIDTH-2:0], step_q});
            remainder   <= apply_sign(r_sign, step_rem[WIDTH-1:0]);
            div_by_zero <= 1'b0;
            overflow    <= ovf_pend;
          end
        end
        default: ;
      endcase
    end
  end

  // Working datapath
  always_ff @(posedge clk) begin
    unique case (state)
      IDLE: begin
        if (div_begin && !op2_zero) begin
          dvd      <= magnitude(div_op1);
          dvs      <= magnitude(div_op2);
          rem      <= '0;
          q_sign   <= div_op1[WIDTH-1] ^ div_op2[WIDTH-1];
          r_sign   <= div_op1[WIDTH-1];
          ovf_pend <= (div_op1 == MIN_NEG) && (div_op2 == '1);
        end
      end
      CALC: begin
        dvd <= {dvd[WIDTH-2:0], step_q};
        rem <= step_rem;
      end
      default: ;
    endcase
  end

endmodule
